// File: rtl/axis_rgb24_packer.sv
// axis_rgb24_packer: packs 24-bit RGB pixels (one per input beat) densely into
// 32-bit words, 4 pixels -> 3 words, LSB-first. A line end (tlast) flushes the
// partial word with tkeep marking the valid bytes.
//
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are both
// high. The output side holds tdata/tkeep/tlast stable while tvalid=1 and
// tready=0, and may reload in the same cycle its current word is taken.
module axis_rgb24_packer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_WIDTH            = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tvalid,
    input  logic                                s00_axis_tlast,
    output logic                                s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tkeep,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    input  logic                                m00_axis_tready
);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nxt;
    logic [23:0]      r_hold;
    logic [23:0]      w_hold_nxt;
    // Set when the pending flush carries two leftover bytes (line ended in phase 1).
    logic             r_flush_wide;
    logic             w_flush_wide_nxt;

    logic [31:0]      r_tdata;
    logic [3:0]       r_tkeep;
    logic             r_tvalid;
    logic             r_tlast;

    logic             w_out_free;
    logic             w_accept;
    logic             w_load;
    logic [31:0]      w_word;
    logic [3:0]       w_keep;
    logic             w_last;
    logic [PIXEL_WIDTH-1:0] w_pix;
    logic             w_unused_bits;

    assign w_pix         = s00_axis_tdata[PIXEL_WIDTH-1:0];
    assign w_unused_bits = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:PIXEL_WIDTH];

    assign w_out_free      = !r_tvalid | m00_axis_tready;
    assign s00_axis_tready = w_out_free & (r_state == ST_ACCEPT) & !rst;
    assign w_accept        = s00_axis_tvalid & s00_axis_tready;

    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tkeep  = r_tkeep;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tlast  = r_tlast;

    // Next-state, packing and output-word selection.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_hold_nxt       = r_hold;
        w_flush_wide_nxt = r_flush_wide;
        w_load           = 1'b0;
        w_word           = 32'h0;
        w_keep           = 4'h0;
        w_last           = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_accept) begin
                    case (r_phase)
                        2'd0: begin
                            if (s00_axis_tlast) begin
                                w_load      = 1'b1;
                                w_word      = {8'h00, w_pix};
                                w_keep      = 4'b0111;
                                w_last      = 1'b1;
                                w_hold_nxt  = 24'h0;
                                w_phase_nxt = 2'd0;
                            end else begin
                                w_hold_nxt  = w_pix;
                                w_phase_nxt = 2'd1;
                            end
                        end
                        2'd1: begin
                            w_load     = 1'b1;
                            w_word     = {w_pix[7:0], r_hold};
                            w_keep     = 4'b1111;
                            w_hold_nxt = {8'h00, w_pix[23:8]};
                            if (s00_axis_tlast) begin
                                w_state_nxt      = ST_FLUSH;
                                w_flush_wide_nxt = 1'b1;
                                w_phase_nxt      = 2'd0;
                            end else begin
                                w_phase_nxt = 2'd2;
                            end
                        end
                        2'd2: begin
                            w_load     = 1'b1;
                            w_word     = {w_pix[15:0], r_hold[15:0]};
                            w_keep     = 4'b1111;
                            w_hold_nxt = {16'h0000, w_pix[23:16]};
                            if (s00_axis_tlast) begin
                                w_state_nxt      = ST_FLUSH;
                                w_flush_wide_nxt = 1'b0;
                                w_phase_nxt      = 2'd0;
                            end else begin
                                w_phase_nxt = 2'd3;
                            end
                        end
                        default: begin
                            w_load      = 1'b1;
                            w_word      = {w_pix, r_hold[7:0]};
                            w_keep      = 4'b1111;
                            w_last      = s00_axis_tlast;
                            w_hold_nxt  = 24'h0;
                            w_phase_nxt = 2'd0;
                        end
                    endcase
                end
            end
            ST_FLUSH: begin
                // The leftover bytes of the line wait in r_hold until the output frees up.
                if (w_out_free) begin
                    w_load = 1'b1;
                    w_last = 1'b1;
                    if (r_flush_wide) begin
                        w_word = {16'h0000, r_hold[15:0]};
                        w_keep = 4'b0011;
                    end else begin
                        w_word = {24'h000000, r_hold[7:0]};
                        w_keep = 4'b0001;
                    end
                    w_hold_nxt       = 24'h0;
                    w_flush_wide_nxt = 1'b0;
                    w_state_nxt      = ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // FSM state, packing phase and leftover bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACCEPT;
            r_phase      <= 2'd0;
            r_hold       <= 24'h0;
            r_flush_wide <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_hold       <= w_hold_nxt;
            r_flush_wide <= w_flush_wide_nxt;
        end
    end

    // Output word register: load a new word or drop valid after a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= 32'h0;
            r_tkeep  <= 4'h0;
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_word;
            r_tkeep  <= w_keep;
            r_tlast  <= w_last;
        end else if (m00_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_rgb24_packer.sv
// Directed bench for axis_rgb24_packer.
module tb_axis_rgb24_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic        rand_en = 1'b0;
    logic [36:0] got_q[$];
    logic [7:0]  byte_q[$];

    axis_rgb24_packer dut (
        .clk             (clk),
        .rst             (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_tready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tkeep  (m_tkeep),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tready (m_tready)
    );

    always #5 clk = ~clk;

    // Record each output word that will transfer at the coming rising edge.
    always @(negedge clk) begin
        if (m_tvalid && m_tready)
            got_q.push_back({m_tlast, m_tkeep, m_tdata});
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_en) m_tready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pixel(input logic [23:0] p, input logic last);
        int t;
        t        = 0;
        s_tdata  = {8'hA5, p};
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready) begin
            n_total++;
            n_fail++;
            $error("FAIL send_timeout: observed tready=0 expected tready=1 for pixel %h", p);
        end
        @(posedge clk);
        #2;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] data,
                               input logic [3:0] keep, input logic last);
        int          t;
        logic [36:0] w;
        t = 0;
        while (got_q.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() == 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s: observed no word expected %h", tag, {last, keep, data});
        end else begin
            w = got_q.pop_front();
            check(tag, 64'(w), 64'({last, keep, data}));
        end
    endtask

    task automatic expect_idle(input string tag);
        repeat (10) @(negedge clk);
        check(tag, 64'(got_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = 32'h0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", 64'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 64'd0);
        check("reset_s_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(s_tready), 64'd1);
        @(posedge clk);
        #2;

        // 1: four pixels, tlast on the 4th.
        send_pixel(24'h221100, 1'b0);
        send_pixel(24'h554433, 1'b0);
        send_pixel(24'h887766, 1'b0);
        send_pixel(24'hBBAA99, 1'b1);
        expect_word("t1_w0", 32'h33221100, 4'b1111, 1'b0);
        expect_word("t1_w1", 32'h77665544, 4'b1111, 1'b0);
        expect_word("t1_w2", 32'hBBAA9988, 4'b1111, 1'b1);
        expect_idle("t1_idle");

        // 2: five pixels, line ends in phase 0.
        send_pixel(24'h221100, 1'b0);
        send_pixel(24'h554433, 1'b0);
        send_pixel(24'h887766, 1'b0);
        send_pixel(24'hBBAA99, 1'b0);
        send_pixel(24'hEEDDCC, 1'b1);
        expect_word("t2_w0", 32'h33221100, 4'b1111, 1'b0);
        expect_word("t2_w1", 32'h77665544, 4'b1111, 1'b0);
        expect_word("t2_w2", 32'hBBAA9988, 4'b1111, 1'b0);
        expect_word("t2_w3", 32'h00EEDDCC, 4'b0111, 1'b1);
        expect_idle("t2_idle");

        // 3: two-pixel line, flush of two bytes.
        send_pixel(24'h221100, 1'b0);
        send_pixel(24'h554433, 1'b1);
        @(negedge clk);
        check("t3_flush_s_tready", 64'(s_tready), 64'd0);
        expect_word("t3_w0", 32'h33221100, 4'b1111, 1'b0);
        expect_word("t3_w1", 32'h00005544, 4'b0011, 1'b1);
        expect_idle("t3_idle");

        // 4: 600-pixel line with random backpressure.
        rand_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic [23:0] p;
            p = 24'(i * 32'h111111);
            byte_q.push_back(p[7:0]);
            byte_q.push_back(p[15:8]);
            byte_q.push_back(p[23:16]);
            send_pixel(p, (i == 599) ? 1'b1 : 1'b0);
        end
        rand_en  = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 450; k++) begin
            logic [31:0] w;
            w = {byte_q[4*k+3], byte_q[4*k+2], byte_q[4*k+1], byte_q[4*k]};
            expect_word($sformatf("t4_w%0d", k), w, 4'b1111, (k == 449) ? 1'b1 : 1'b0);
        end
        expect_idle("t4_idle");

        // 5: reset after the 2nd pixel with a word stalled at the output.
        m_tready = 1'b0;
        send_pixel(24'h221100, 1'b0);
        send_pixel(24'h554433, 1'b0);
        @(negedge clk);
        check("t5_pending", 64'({m_tvalid, m_tkeep, m_tdata}), 64'({1'b1, 4'b1111, 32'h33221100}));
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_s_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("t5_after_rst", 64'({m_tvalid, m_tlast, m_tkeep, m_tdata}), 64'd0);
        @(posedge clk);
        #2;
        m_tready = 1'b1;
        expect_idle("t5_dropped");
        send_pixel(24'h221100, 1'b0);
        send_pixel(24'h554433, 1'b0);
        send_pixel(24'h887766, 1'b0);
        send_pixel(24'hBBAA99, 1'b1);
        expect_word("t5_w0", 32'h33221100, 4'b1111, 1'b0);
        expect_word("t5_w1", 32'h77665544, 4'b1111, 1'b0);
        expect_word("t5_w2", 32'hBBAA9988, 4'b1111, 1'b1);
        expect_idle("t5_idle");

        // 6: three-pixel line with a 5-cycle downstream stall.
        m_tready = 1'b0;
        send_pixel(24'h221100, 1'b0);
        send_pixel(24'h554433, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t6_stall%0d", c),
                  64'({m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready}),
                  64'({1'b1, 1'b0, 4'b1111, 32'h33221100, 1'b0}));
            @(posedge clk);
            #2;
        end
        m_tready = 1'b1;
        send_pixel(24'h887766, 1'b1);
        expect_word("t6_w0", 32'h33221100, 4'b1111, 1'b0);
        expect_word("t6_w1", 32'h77665544, 4'b1111, 1'b0);
        expect_word("t6_w2", 32'h00000088, 4'b0001, 1'b1);
        expect_idle("t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
